window_conv: RTL and testbench
==============================

Name: window_conv

Overview:
- Consumes the WIN_SIZE x WIN_SIZE pixel window stream from the line-buffer window stage.
- Computes one output pixel per window as a per-component 2-D convolution with signed programmable coefficients, then rounds, shifts and saturates the result.
- Fully pipelined at one window per clock, with AXI4-Stream backpressure. Feeds the downstream video pipeline.

Parameters:
- WIN_SIZE, 5, window edge length; the window holds WIN_SIZE² taps.
- PX_WIDTH, 30, pixel width in the window word.
- COMP_WIDTH, 10, bits per colour component; COMP_CNT = PX_WIDTH / COMP_WIDTH.
- COEF_WIDTH, 8, signed coefficient width.
- FRAC_BITS, 4, fractional bits of a coefficient.
- TDATA_WIDTH_I, 752, input tdata width; must be ≥ WIN_SIZE²·PX_WIDTH.
- TDATA_WIDTH_O, 32, output tdata width; must be ≥ PX_WIDTH.

Ports:
- clk_i, input, 1, single clock.
- rst_i, input, 1, reset: synchronous, active-high.
- window_i, axi4_stream_if.slave, TDATA_WIDTH_I, window stream. Tap (y,x) is at bits [(y·WIN_SIZE+x+1)·PX_WIDTH-1 -: PX_WIDTH].
- video_o, axi4_stream_if.master, TDATA_WIDTH_O, filtered pixels in bits [PX_WIDTH-1:0]; upper bits are 0.
- coef_i, input, WIN_SIZE²·COEF_WIDTH, coefficient array. Coefficient k = y·WIN_SIZE+x is at bits [(k+1)·COEF_WIDTH-1 -: COEF_WIDTH].
- coef_wr_i, input, 1, one-cycle strobe that captures coef_i into the pending register.
- coef_pending_o, output, 1, high while a captured set is waiting for the next frame start.

Behaviour:
- Global enable: en = !video_o.tvalid || video_o.tready.
  - window_i.tready = en.
  - All pipeline registers, including valid/tlast/tuser sidebands, advance only when en=1.
  - A beat is accepted when window_i.tvalid && en.
- Pipeline stages, latency L = 2 + ceil(log2(WIN_SIZE²)); L = 7 for defaults:
  - S1: per component c and tap k, register product = signed(coef_act[k]) × zero-extended pixel component.
  - S2 … S(L-1): registered pairwise adder tree, one tree level per stage. An odd element passes through that level registered.
  - SL: add 2^(FRAC_BITS-1), arithmetic shift right by FRAC_BITS, clamp to [0, 2^COMP_WIDTH-1], register the result into video_o.tdata.
- Width rules:
  - Product width is COEF_WIDTH+COMP_WIDTH+1.
  - Accumulator width is product width + ceil(log2(WIN_SIZE²)).
  - No intermediate overflow is allowed.
- Sidebands: tlast and tuser of an accepted beat appear on video_o with the same beat, L cycles later with no stalls. Bubbles (tvalid=0) propagate and produce no output beats.
- Coefficients:
  - coef_act resets to identity: centre tap k = (WIN_SIZE²-1)/2 = 1<<FRAC_BITS, all others 0.
  - coef_wr_i=1: coef_i is copied to coef_pend and coef_pending_o is set. A later write before the swap overwrites coef_pend.
  - Swap rule: on acceptance of a beat with tuser=1 while coef_pending_o=1, coef_act <= coef_pend and coef_pending_o clears. The tuser beat itself already uses the new set (the swap mux sits in front of S1).
  - coef_wr_i in the same cycle as the swap: the old coef_pend is applied, the new value becomes pending, and coef_pending_o stays 1.
  - A set is never applied mid-frame.
- Reset (at any time, including mid-frame):
  - video_o.tvalid, tlast, tuser and tdata all go to 0.
  - All pipeline valids clear, so in-flight beats are dropped.
  - coef_act returns to identity; coef_pend=0; coef_pending_o=0.
  - window_i.tready = 1 in the first cycle after reset.
- Backpressure: while video_o.tvalid=1 and tready=0, the output holds tdata, tlast and tuser stable and window_i.tready=0. No beat is lost or duplicated.

Test Plan:
- Identity after reset; stream a 6x4 frame with centre pixel components 0x155/0x2AA/0x3FF -> identical pixels out 7 cycles after acceptance; tuser on beat 0, tlast on every 6th beat.
- Load all-ones coefficients (value 1<<FRAC_BITS = 16); all taps = 40 per component -> component = 25·40 = 1000 (0x3E8).
- Saturation, with all taps = 1023 per component:
  - same all-ones set -> output 1023;
  - all coefficients = -16 -> output 0.
- Rounding: centre coef = 8 (0.5), others 0; centre component 3 -> (24+8)>>4 = 2.
- Coefficient switch: write a new set mid-frame -> coef_pending_o=1 and the current frame is unchanged; the next tuser beat and all later beats use the new set, and coef_pending_o clears. Also issue coef_wr_i in the same cycle as the tuser accept and check the override behaviour above.
- Backpressure and reset:
  - random tready (50%) over 100 beats -> output sequence matches the reference model exactly;
  - assert rst_i mid-frame -> video_o.tvalid=0 the next cycle, no stale beats after release, identity coefficients restored.

Source files
------------

// File: rtl/window_conv.sv
// rtl/window_conv.sv - WIN_SIZE x WIN_SIZE per-component convolution with frame-synchronous coefficient swap
module window_conv #(
    parameter int WIN_SIZE      = 5,
    parameter int PX_WIDTH      = 30,
    parameter int COMP_WIDTH    = 10,
    parameter int COEF_WIDTH    = 8,
    parameter int FRAC_BITS     = 4,
    parameter int TDATA_WIDTH_I = 752,
    parameter int TDATA_WIDTH_O = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [TDATA_WIDTH_I-1:0]              window_tdata,
    input  logic                                  window_tvalid,
    output logic                                  window_tready,
    input  logic                                  window_tlast,
    input  logic                                  window_tuser,
    output logic [TDATA_WIDTH_O-1:0]              video_tdata,
    output logic                                  video_tvalid,
    input  logic                                  video_tready,
    output logic                                  video_tlast,
    output logic                                  video_tuser,
    input  logic [WIN_SIZE*WIN_SIZE*COEF_WIDTH-1:0] coef_i,
    input  logic                                  coef_wr_i,
    output logic                                  coef_pending_o
);
    localparam int TAPS     = WIN_SIZE * WIN_SIZE;
    localparam int COMP_CNT = PX_WIDTH / COMP_WIDTH;
    localparam int LEVELS   = $clog2(TAPS);
    localparam int PROD_W   = COEF_WIDTH + COMP_WIDTH + 1;
    localparam int ACC_W    = PROD_W + LEVELS;
    localparam int HALF     = (TAPS + 1) / 2;
    localparam int CENTRE   = (TAPS - 1) / 2;
    localparam int CW       = TAPS * COEF_WIDTH;

    localparam logic [CW-1:0] COEF_ID =
        {{(CW-COEF_WIDTH){1'b0}}, COEF_WIDTH'(1 << FRAC_BITS)} << (CENTRE * COEF_WIDTH);
    localparam logic signed [ACC_W-1:0] RND_V = ACC_W'(1 << (FRAC_BITS - 1));
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 << COMP_WIDTH) - 1);

    logic en, accept, swap;
    logic [CW-1:0] coef_act, coef_pend, coef_use;
    logic [LEVELS:0] vld, lst, usr;
    logic signed [PROD_W-1:0] prod [COMP_CNT][TAPS];
    // Index TAPS of each level is a permanent zero so the odd element pairs with it.
    logic signed [ACC_W-1:0]  tree [COMP_CNT][LEVELS+1][TAPS+1];
    logic signed [ACC_W-1:0]  rnd  [COMP_CNT];
    logic signed [ACC_W-1:0]  shf  [COMP_CNT];
    logic [COMP_CNT*COMP_WIDTH-1:0] px_next;
    logic unused_bits;

    assign en            = !video_tvalid || video_tready;
    assign window_tready = en;
    assign accept        = window_tvalid && en;
    assign swap          = accept && window_tuser && coef_pending_o;
    // The frame-start beat itself already sees the pending set.
    assign coef_use      = swap ? coef_pend : coef_act;
    assign unused_bits   = ^window_tdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            coef_act       <= COEF_ID;
            coef_pend      <= '0;
            coef_pending_o <= 1'b0;
        end else begin
            if (swap) begin
                coef_act <= coef_pend;
            end
            if (coef_wr_i) begin
                coef_pend      <= coef_i;
                coef_pending_o <= 1'b1;
            end else if (swap) begin
                coef_pending_o <= 1'b0;
            end
        end
    end

    for (genvar c = 0; c < COMP_CNT; c++) begin : g_comp
        for (genvar k = 0; k < TAPS; k++) begin : g_tap
            logic signed [PROD_W-1:0] cf_x, px_x;
            assign cf_x = PROD_W'($signed(coef_use[k*COEF_WIDTH +: COEF_WIDTH]));
            assign px_x = PROD_W'(window_tdata[k*PX_WIDTH + c*COMP_WIDTH +: COMP_WIDTH]);
            assign prod[c][k] = cf_x * px_x;
        end
        assign rnd[c] = tree[c][LEVELS][0] + RND_V;
        assign shf[c] = rnd[c] >>> FRAC_BITS;
        assign px_next[c*COMP_WIDTH +: COMP_WIDTH] =
            shf[c][ACC_W-1] ? '0 :
            (shf[c] > MAX_V) ? {COMP_WIDTH{1'b1}} : shf[c][COMP_WIDTH-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (en) begin
            for (int c = 0; c < COMP_CNT; c++) begin
                for (int k = 0; k < TAPS; k++) begin
                    tree[c][0][k] <= ACC_W'(prod[c][k]);
                end
                tree[c][0][TAPS] <= '0;
                for (int l = 0; l < LEVELS; l++) begin
                    for (int i = 0; i < HALF; i++) begin
                        tree[c][l+1][i] <= tree[c][l][2*i] + tree[c][l][2*i+1];
                    end
                    for (int i = HALF; i <= TAPS; i++) begin
                        tree[c][l+1][i] <= '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld          <= '0;
            lst          <= '0;
            usr          <= '0;
            video_tvalid <= 1'b0;
            video_tlast  <= 1'b0;
            video_tuser  <= 1'b0;
            video_tdata  <= '0;
        end else if (en) begin
            vld          <= {vld[LEVELS-1:0], accept};
            lst          <= {lst[LEVELS-1:0], window_tlast};
            usr          <= {usr[LEVELS-1:0], window_tuser};
            video_tvalid <= vld[LEVELS];
            video_tlast  <= lst[LEVELS];
            video_tuser  <= usr[LEVELS];
            video_tdata  <= TDATA_WIDTH_O'(px_next);
        end
    end
endmodule

// File: tb/tb_window_conv.sv
// tb/tb_window_conv.sv - directed self-checking bench for window_conv
module tb_window_conv;
    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic [751:0] window_tdata = '0;
    logic         window_tvalid = 1'b0;
    logic         window_tready;
    logic         window_tlast = 1'b0;
    logic         window_tuser = 1'b0;
    logic [31:0]  video_tdata;
    logic         video_tvalid;
    logic         video_tready = 1'b1;
    logic         video_tlast;
    logic         video_tuser;
    logic [199:0] coef_i = '0;
    logic         coef_wr_i = 1'b0;
    logic         coef_pending_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stall_err = 0;
    bit bp_en = 1'b0;
    logic [31:0] q_data[$];
    bit q_last[$];
    bit q_user[$];
    int q_cyc[$];
    int acc_cyc[$];
    logic prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic prev_last, prev_user;

    window_conv dut (
        .clk_i(clk), .rst_i(rst_i),
        .window_tdata(window_tdata), .window_tvalid(window_tvalid), .window_tready(window_tready),
        .window_tlast(window_tlast), .window_tuser(window_tuser),
        .video_tdata(video_tdata), .video_tvalid(video_tvalid), .video_tready(video_tready),
        .video_tlast(video_tlast), .video_tuser(video_tuser),
        .coef_i(coef_i), .coef_wr_i(coef_wr_i), .coef_pending_o(coef_pending_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_i) begin
            if (prev_stall && (video_tdata !== prev_data || video_tlast !== prev_last ||
                               video_tuser !== prev_user))
                stall_err++;
            if (video_tvalid && video_tready) begin
                q_data.push_back(video_tdata);
                q_last.push_back(video_tlast);
                q_user.push_back(video_tuser);
                q_cyc.push_back(cyc);
            end
        end
        prev_stall = !rst_i && video_tvalid && !video_tready;
        prev_data  = video_tdata;
        prev_last  = video_tlast;
        prev_user  = video_tuser;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) video_tready = 1'($urandom_range(0, 1));
        end
    end

    function automatic logic [29:0] px(input int a, input int b, input int c);
        return {c[9:0], b[9:0], a[9:0]};
    endfunction

    function automatic logic [751:0] win(input logic [29:0] fill, input logic [29:0] t0,
                                         input logic [29:0] ctr);
        logic [751:0] w;
        w = '0;
        for (int k = 0; k < 25; k++) w[k*30 +: 30] = fill;
        w[29:0] = t0;
        w[12*30 +: 30] = ctr;
        return w;
    endfunction

    function automatic logic [199:0] coefs(input logic [7:0] fill, input logic [7:0] c0,
                                           input logic [7:0] ctr);
        logic [199:0] v;
        for (int k = 0; k < 25; k++) v[k*8 +: 8] = fill;
        v[7:0] = c0;
        v[12*8 +: 8] = ctr;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete(); q_last.delete(); q_user.delete(); q_cyc.delete(); acc_cyc.delete();
    endtask

    task automatic write_coef(input logic [199:0] v);
        coef_i = v;
        coef_wr_i = 1'b1;
        tick();
        coef_wr_i = 1'b0;
    endtask

    task automatic send_beat(input logic [751:0] d, input logic l, input logic u,
                             input logic wr, input logic [199:0] wv);
        bit acc;
        acc = 1'b0;
        window_tdata = d; window_tlast = l; window_tuser = u; window_tvalid = 1'b1;
        if (wr) begin
            coef_i = wv;
            coef_wr_i = 1'b1;
        end
        for (int n = 0; n < 500 && !acc; n++) begin
            @(negedge clk);
            acc = window_tready;
            if (acc) acc_cyc.push_back(cyc);
            tick();
            coef_wr_i = 1'b0;
        end
        window_tvalid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: window_tready stayed %b, required 1", window_tready);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;
        checks++; if (video_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", video_tvalid); end
        checks++; if (video_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata: got %h expected 0", video_tdata); end
        checks++; if (video_tlast !== 1'b0 || video_tuser !== 1'b0) begin errors++; $display("FAIL reset_sideband: got %b%b expected 00", video_tlast, video_tuser); end
        checks++; if (window_tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b expected 1", window_tready); end
        checks++; if (coef_pending_o !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", coef_pending_o); end
    endtask

    task automatic test_identity();
        logic [31:0] exp;
        clear_q();
        for (int i = 0; i < 24; i++)
            send_beat(win(px(12'h123, 12'h2F0, 12'h0AB), px(7, 8, 9), px(12'h155 ^ i, 12'h2AA, 12'h3FF)),
                      (i % 6) == 5, i == 0, 1'b0, '0);
        repeat (12) tick();
        checks++; if (q_data.size() != 24) begin errors++; $display("FAIL ident_count: got %0d expected 24", q_data.size()); end
        for (int i = 0; i < 24 && i < q_data.size(); i++) begin
            exp = {2'b00, px(12'h155 ^ i, 12'h2AA, 12'h3FF)};
            checks++; if (q_data[i] !== exp) begin errors++; $display("FAIL ident_data beat %0d: got %h expected %h", i, q_data[i], exp); end
            checks++; if (q_last[i] !== ((i % 6) == 5)) begin errors++; $display("FAIL ident_last beat %0d: got %b", i, q_last[i]); end
            checks++; if (q_user[i] !== (i == 0)) begin errors++; $display("FAIL ident_user beat %0d: got %b", i, q_user[i]); end
            checks++; if (q_cyc[i] - acc_cyc[i] != 7) begin errors++; $display("FAIL ident_latency beat %0d: got %0d expected 7", i, q_cyc[i] - acc_cyc[i]); end
        end
    endtask

    task automatic test_all_ones();
        clear_q();
        write_coef(coefs(8'd16, 8'd16, 8'd16));
        checks++; if (coef_pending_o !== 1'b1) begin errors++; $display("FAIL ones_pending_set: got %b expected 1", coef_pending_o); end
        send_beat(win(px(40, 40, 40), px(40, 40, 40), px(40, 40, 40)), 1'b0, 1'b1, 1'b0, '0);
        checks++; if (coef_pending_o !== 1'b0) begin errors++; $display("FAIL ones_pending_clr: got %b expected 0", coef_pending_o); end
        repeat (10) tick();
        checks++;
        if (q_data.size() != 1 || q_data[0] !== {2'b00, px(1000, 1000, 1000)}) begin
            errors++; $display("FAIL ones_data: got %0d beats, first %h expected %h", q_data.size(),
                               (q_data.size() > 0) ? q_data[0] : 32'hx, {2'b00, px(1000, 1000, 1000)});
        end
    endtask

    task automatic test_saturation();
        clear_q();
        send_beat(win(px(1023, 1023, 1023), px(1023, 1023, 1023), px(1023, 1023, 1023)), 1'b0, 1'b0, 1'b0, '0);
        write_coef(coefs(8'hF0, 8'hF0, 8'hF0));
        send_beat(win(px(1023, 1023, 1023), px(1023, 1023, 1023), px(1023, 1023, 1023)), 1'b0, 1'b1, 1'b0, '0);
        repeat (10) tick();
        checks++; if (q_data.size() != 2) begin errors++; $display("FAIL sat_count: got %0d expected 2", q_data.size()); end
        if (q_data.size() == 2) begin
            checks++; if (q_data[0] !== {2'b00, px(1023, 1023, 1023)}) begin errors++; $display("FAIL sat_high: got %h expected 3fffffff", q_data[0]); end
            checks++; if (q_data[1] !== 32'h0) begin errors++; $display("FAIL sat_low: got %h expected 0", q_data[1]); end
        end
    endtask

    task automatic test_rounding();
        clear_q();
        write_coef(coefs(8'd0, 8'd0, 8'd8));
        send_beat(win(px(1023, 1023, 1023), px(1023, 1023, 1023), px(3, 5, 1023)), 1'b0, 1'b1, 1'b0, '0);
        repeat (10) tick();
        checks++;
        if (q_data.size() != 1 || q_data[0] !== {2'b00, px(2, 3, 512)}) begin
            errors++; $display("FAIL round_data: got %0d beats, first %h expected %h", q_data.size(),
                               (q_data.size() > 0) ? q_data[0] : 32'hx, {2'b00, px(2, 3, 512)});
        end
    endtask

    task automatic test_coef_switch();
        logic [751:0] w;
        logic [31:0] exp [8];
        w = win(px(7, 7, 7), px(7, 7, 7), px(100, 200, 300));
        exp[0] = {2'b00, px(100, 200, 300)}; exp[1] = exp[0]; exp[2] = exp[0];
        exp[3] = {2'b00, px(200, 400, 600)}; exp[4] = exp[3];
        exp[5] = {2'b00, px(300, 600, 900)}; exp[6] = exp[5];
        exp[7] = {2'b00, px(50, 100, 150)};
        clear_q();
        write_coef(coefs(8'd0, 8'd0, 8'd16));
        send_beat(w, 1'b0, 1'b1, 1'b0, '0);
        send_beat(w, 1'b0, 1'b0, 1'b0, '0);
        write_coef(coefs(8'd0, 8'd0, 8'd32));
        checks++; if (coef_pending_o !== 1'b1) begin errors++; $display("FAIL sw_pending_mid: got %b expected 1", coef_pending_o); end
        send_beat(w, 1'b1, 1'b0, 1'b0, '0);
        send_beat(w, 1'b0, 1'b1, 1'b0, '0);
        checks++; if (coef_pending_o !== 1'b0) begin errors++; $display("FAIL sw_pending_clr: got %b expected 0", coef_pending_o); end
        send_beat(w, 1'b1, 1'b0, 1'b0, '0);
        write_coef(coefs(8'd0, 8'd0, 8'd48));
        send_beat(w, 1'b0, 1'b1, 1'b1, coefs(8'd0, 8'd0, 8'd8));
        checks++; if (coef_pending_o !== 1'b1) begin errors++; $display("FAIL sw_override_pending: got %b expected 1", coef_pending_o); end
        send_beat(w, 1'b1, 1'b0, 1'b0, '0);
        send_beat(w, 1'b0, 1'b1, 1'b0, '0);
        checks++; if (coef_pending_o !== 1'b0) begin errors++; $display("FAIL sw_final_pending: got %b expected 0", coef_pending_o); end
        repeat (10) tick();
        checks++; if (q_data.size() != 8) begin errors++; $display("FAIL sw_count: got %0d expected 8", q_data.size()); end
        for (int i = 0; i < 8 && i < q_data.size(); i++) begin
            checks++; if (q_data[i] !== exp[i]) begin errors++; $display("FAIL sw_data beat %0d: got %h expected %h", i, q_data[i], exp[i]); end
        end
    endtask

    task automatic test_backpressure();
        int a [3];
        int b [3];
        int v;
        logic [31:0] exp [100];
        int waited;
        write_coef(coefs(8'd0, 8'hF0, 8'd32));
        clear_q();
        stall_err = 0;
        bp_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            exp[i] = '0;
            for (int c = 0; c < 3; c++) begin
                a[c] = (i * 37 + c * 101) % 1024;
                b[c] = (i * 53 + c * 211 + 300) % 1024;
                v = 2 * a[c] - b[c];
                if (v < 0) v = 0;
                if (v > 1023) v = 1023;
                exp[i][c*10 +: 10] = v[9:0];
            end
            send_beat(win(px(999, 999, 999), px(b[0], b[1], b[2]), px(a[0], a[1], a[2])),
                      (i % 10) == 9, i == 0, 1'b0, '0);
            if ($urandom_range(0, 3) == 0) tick();
        end
        waited = 0;
        while (q_data.size() < 100 && waited < 3000) begin
            tick();
            waited++;
        end
        bp_en = 1'b0;
        video_tready = 1'b1;
        repeat (10) tick();
        checks++; if (q_data.size() != 100) begin errors++; $display("FAIL bp_count: got %0d expected 100", q_data.size()); end
        for (int i = 0; i < 100 && i < q_data.size(); i++) begin
            checks++;
            if (q_data[i] !== exp[i] || q_last[i] !== ((i % 10) == 9) || q_user[i] !== (i == 0)) begin
                errors++; $display("FAIL bp_beat %0d: got %h/%b/%b expected %h/%b/%b", i, q_data[i], q_last[i],
                                   q_user[i], exp[i], (i % 10) == 9, i == 0);
            end
        end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable stall cycles expected 0", stall_err); end
    endtask

    task automatic test_reset_mid_frame();
        logic [751:0] w;
        w = win(px(1, 1, 1), px(500, 500, 500), px(10, 20, 30));
        video_tready = 1'b1;
        write_coef(coefs(8'd0, 8'd0, 8'd32));
        for (int i = 0; i < 3; i++) send_beat(w, 1'b0, 1'b0, 1'b0, '0);
        rst_i = 1'b1;
        tick();
        checks++; if (video_tvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_tvalid: got %b expected 0", video_tvalid); end
        checks++; if (coef_pending_o !== 1'b0) begin errors++; $display("FAIL rst_mid_pending: got %b expected 0", coef_pending_o); end
        rst_i = 1'b0;
        clear_q();
        repeat (15) tick();
        checks++; if (q_data.size() != 0) begin errors++; $display("FAIL rst_mid_stale: got %0d beats expected 0", q_data.size()); end
        send_beat(w, 1'b0, 1'b0, 1'b0, '0);
        repeat (10) tick();
        checks++;
        if (q_data.size() != 1 || q_data[0] !== {2'b00, px(10, 20, 30)}) begin
            errors++; $display("FAIL rst_mid_identity: got %0d beats, first %h expected %h", q_data.size(),
                               (q_data.size() > 0) ? q_data[0] : 32'hx, {2'b00, px(10, 20, 30)});
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_all_ones();
        test_saturation();
        test_rounding();
        test_coef_switch();
        test_backpressure();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
